// File: rtl/uart_slot_master_if.sv
// Slot bus plus the local TX/RX byte streams of the UART slot master.
interface uart_slot_master_if;
  // Local TX stream (source -> master)
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  // Local RX stream (master -> sink)
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  // UART slot
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (
    input  tx_data, tx_valid, rx_ready, rd_data,
    output tx_ready, rx_data, rx_valid, cs, read, write, addr, wr_data
  );

  modport slave (
    output tx_data, tx_valid, rx_ready, rd_data,
    input  tx_ready, rx_data, rx_valid, cs, read, write, addr, wr_data
  );
endinterface

// File: rtl/uart_slot_master.sv
// Hardware initiator for the UART slot: programs the divisor, polls status,
// moves bytes between local valid/ready streams and the UART FIFOs.
module uart_slot_master #(
  parameter logic [10:0] DEFAULT_DVSR = 11'd650,
  parameter int unsigned POLL_GAP     = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [10:0]        dvsr_in,
  input  logic               cfg_load,
  uart_slot_master_if.master bus
);

  typedef enum logic [2:0] {StCfg, StPoll, StRxPop, StTxWr, StGap} state_e;

  // GAP holds for POLL_GAP idle cycles; with no gap it is bypassed entirely.
  localparam logic [7:0] GapLoad     = (POLL_GAP == 0) ? 8'd0 : 8'(POLL_GAP - 1);
  localparam state_e     AfterAccess = (POLL_GAP == 0) ? StPoll : StGap;

  localparam logic [4:0] AddrStatus = 5'd0;
  localparam logic [4:0] AddrDvsr   = 5'd1;
  localparam logic [4:0] AddrTx     = 5'd2;
  localparam logic [4:0] AddrRx     = 5'd3;

  state_e      state_q, state_d;
  logic        run_q;
  logic [7:0]  gap_q, gap_d;
  logic        cfg_pending_q, cfg_pending_d;
  logic [10:0] dvsr_q, dvsr_d;
  logic [7:0]  tx_buf_q, tx_buf_d;
  logic        tx_full_q, tx_full_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        last_tx_q, last_tx_d;  // 1: TX was served last, 0: RX
  logic        cs_q, cs_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        rx_elig, tx_elig;
  logic        unused_rd;

  assign unused_rd = ^bus.rd_data[31:10];

  // Next-state: stream buffers, config latch and the access sequencer.
  always_comb begin
    state_d       = state_q;
    gap_d         = gap_q;
    cfg_pending_d = cfg_pending_q;
    dvsr_d        = dvsr_q;
    tx_buf_d      = tx_buf_q;
    tx_full_d     = tx_full_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    last_tx_d     = last_tx_q;
    rx_elig       = 1'b0;
    tx_elig       = 1'b0;

    if (bus.tx_valid && !tx_full_q) begin
      tx_buf_d  = bus.tx_data;
      tx_full_d = 1'b1;
    end
    if (rx_valid_q && bus.rx_ready) begin
      rx_valid_d = 1'b0;
    end

    if (!run_q) begin
      // First cycle out of reset: issue the divisor write next.
      state_d = StCfg;
    end else begin
      unique case (state_q)
        StCfg: begin
          cfg_pending_d = 1'b0;
          state_d       = AfterAccess;
          gap_d         = GapLoad;
        end
        StPoll: begin
          rx_elig = !bus.rd_data[8] && !rx_valid_q;
          tx_elig = tx_full_q && !bus.rd_data[9];
          if (cfg_pending_q) begin
            state_d = StCfg;
          end else if (rx_elig && (!tx_elig || last_tx_q)) begin
            rx_data_d  = bus.rd_data[7:0];
            rx_valid_d = 1'b1;
            state_d    = StRxPop;
          end else if (tx_elig) begin
            state_d = StTxWr;
          end else begin
            state_d = AfterAccess;
            gap_d   = GapLoad;
          end
        end
        StRxPop: begin
          last_tx_d = 1'b0;
          state_d   = AfterAccess;
          gap_d     = GapLoad;
        end
        StTxWr: begin
          tx_full_d = 1'b0;
          last_tx_d = 1'b1;
          state_d   = AfterAccess;
          gap_d     = GapLoad;
        end
        StGap: begin
          if (gap_q == 8'd0) begin
            state_d = StPoll;
          end else begin
            gap_d = gap_q - 8'd1;
          end
        end
        default: state_d = StCfg;
      endcase
    end

    // A new load wins over the clear of an in-flight CFG so the latest value is written.
    if (cfg_load) begin
      dvsr_d        = dvsr_in;
      cfg_pending_d = 1'b1;
    end
  end

  // Slot outputs for the upcoming cycle, decoded from the next state so they leave a flop.
  always_comb begin
    cs_d      = 1'b0;
    read_d    = 1'b0;
    write_d   = 1'b0;
    addr_d    = AddrStatus;
    wr_data_d = 32'd0;
    unique case (state_d)
      StCfg: begin
        cs_d      = 1'b1;
        write_d   = 1'b1;
        addr_d    = AddrDvsr;
        wr_data_d = {21'd0, dvsr_d};
      end
      StPoll: begin
        cs_d   = 1'b1;
        read_d = 1'b1;
      end
      StRxPop: begin
        cs_d    = 1'b1;
        write_d = 1'b1;
        addr_d  = AddrRx;
      end
      StTxWr: begin
        cs_d      = 1'b1;
        write_d   = 1'b1;
        addr_d    = AddrTx;
        wr_data_d = {24'd0, tx_buf_q};
      end
      default: ;
    endcase
  end

  // State and output registers; reset drops all strobes immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StCfg;
      run_q         <= 1'b0;
      gap_q         <= 8'd0;
      cfg_pending_q <= 1'b1;
      dvsr_q        <= DEFAULT_DVSR;
      tx_buf_q      <= 8'd0;
      tx_full_q     <= 1'b0;
      rx_data_q     <= 8'd0;
      rx_valid_q    <= 1'b0;
      last_tx_q     <= 1'b0;
      cs_q          <= 1'b0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      addr_q        <= 5'd0;
      wr_data_q     <= 32'd0;
    end else begin
      state_q       <= state_d;
      run_q         <= 1'b1;
      gap_q         <= gap_d;
      cfg_pending_q <= cfg_pending_d;
      dvsr_q        <= dvsr_d;
      tx_buf_q      <= tx_buf_d;
      tx_full_q     <= tx_full_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      last_tx_q     <= last_tx_d;
      cs_q          <= cs_d;
      read_q        <= read_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wr_data_q     <= wr_data_d;
    end
  end

  assign bus.tx_ready = ~tx_full_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.cs       = cs_q;
  assign bus.read     = read_q;
  assign bus.write    = write_q;
  assign bus.addr     = addr_q;
  assign bus.wr_data  = wr_data_q;

endmodule

// File: tb/tb_uart_slot_master.sv
// Bench for uart_slot_master: models the UART slot and the local streams at
// transaction level and predicts the access issued every cycle.
module tb_uart_slot_master;

  localparam logic [10:0] DefDvsr = 11'd650;
  localparam int KIdle = 0, KCfg = 1, KPoll = 2, KRx = 3, KTx = 4, KBad = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] dvsr_in;
  logic        cfg_load;

  uart_slot_master_if bus ();

  uart_slot_master #(.DEFAULT_DVSR(DefDvsr), .POLL_GAP(0)) dut (
    .clk     (clk),
    .reset   (reset),
    .dvsr_in (dvsr_in),
    .cfg_load(cfg_load),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state
  logic [7:0]  tx_sb[$];   // bytes accepted on the TX stream, not yet written to the slot
  logic [7:0]  rx_exp[$];  // byte the master should be holding on the RX stream
  logic [7:0]  rxf[$];     // UART RX FIFO contents
  logic        slot_tx_full;
  logic        cfg_pend_m;
  logic [10:0] dvsr_m;
  logic        last_tx_m;
  int          cur_kind;
  bit          rnd_mode;

  // Observed-access bookkeeping
  int          n_tx_obs, n_rx_obs, n_repeat, last_svc;
  logic [7:0]  last_tx_byte;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] exp_vec(input int k);
    case (k)
      KCfg:    return {1'b1, 1'b0, 1'b1, 5'd1, 21'd0, dvsr_m};
      KPoll:   return {1'b1, 1'b1, 1'b0, 5'd0, 32'd0};
      KRx:     return {1'b1, 1'b0, 1'b1, 5'd3, 32'd0};
      KTx:     return {1'b1, 1'b0, 1'b1, 5'd2, 24'd0, tx_sb[0]};
      default: return 40'd0;
    endcase
  endfunction

  function automatic int obs_kind();
    if (!bus.cs) return KIdle;
    if (bus.read && !bus.write && bus.addr == 5'd0) return KPoll;
    if (bus.write && !bus.read) begin
      if (bus.addr == 5'd1) return KCfg;
      if (bus.addr == 5'd2) return KTx;
      if (bus.addr == 5'd3) return KRx;
    end
    return KBad;
  endfunction

  task automatic model_reset();
    tx_sb.delete();
    rx_exp.delete();
    cfg_pend_m = 1'b1;
    dvsr_m     = DefDvsr;
    last_tx_m  = 1'b0;
    cur_kind   = KIdle;
    last_svc   = KIdle;
  endtask

  // One clock cycle: drive slot response, predict next access, check after the edge.
  task automatic tick();
    int          nxt, prev, k;
    bit          txh, rxh, cfgl, rx_e, tx_e;
    logic [7:0]  txd;
    logic [10:0] dvl;
    if (rnd_mode) begin
      slot_tx_full = ($urandom_range(0, 9) < 3);
      if (rxf.size() < 8 && $urandom_range(0, 3) == 0) rxf.push_back(8'($urandom));
      bus.tx_valid = 1'($urandom_range(0, 1));
      bus.tx_data  = 8'($urandom);
      bus.rx_ready = ($urandom_range(0, 2) != 0);
      cfg_load     = ($urandom_range(0, 49) == 0);
      dvsr_in      = 11'($urandom);
    end
    bus.rd_data = {22'd0, slot_tx_full, (rxf.size() == 0), (rxf.size() != 0) ? rxf[0] : 8'd0};
    txh  = bus.tx_valid && (tx_sb.size() == 0) && !reset;
    txd  = bus.tx_data;
    rxh  = bus.rx_ready && (rx_exp.size() != 0);
    cfgl = cfg_load;
    dvl  = dvsr_in;
    if (reset) nxt = KIdle;
    else if (cur_kind == KIdle) nxt = KCfg;
    else if (cur_kind == KPoll) begin
      rx_e = (rxf.size() != 0) && (rx_exp.size() == 0);
      tx_e = (tx_sb.size() != 0) && !slot_tx_full;
      if (cfg_pend_m) nxt = KCfg;
      else if (rx_e && tx_e) nxt = last_tx_m ? KRx : KTx;
      else if (rx_e) nxt = KRx;
      else if (tx_e) nxt = KTx;
      else nxt = KPoll;
    end else nxt = KPoll;
    prev = cur_kind;
    @(posedge clk);
    #1;
    if (reset) begin
      model_reset();
    end else begin
      if (prev == KCfg) cfg_pend_m = 1'b0;
      if (prev == KTx) begin void'(tx_sb.pop_front()); last_tx_m = 1'b1; end
      if (prev == KRx) begin void'(rxf.pop_front()); last_tx_m = 1'b0; end
      if (rxh) void'(rx_exp.pop_front());
      if (nxt == KRx) rx_exp.push_back(rxf[0]);
      if (txh) tx_sb.push_back(txd);
      if (cfgl) begin cfg_pend_m = 1'b1; dvsr_m = dvl; end
      cur_kind = nxt;
    end
    chk("tx_ready", 64'(bus.tx_ready), 64'(tx_sb.size() == 0));
    chk("rx_valid", 64'(bus.rx_valid), 64'(rx_exp.size() != 0));
    if (rx_exp.size() != 0) chk("rx_data", 64'(bus.rx_data), 64'(rx_exp[0]));
    chk("slot_access", 64'({bus.cs, bus.read, bus.write, bus.addr, bus.wr_data}),
        64'(exp_vec(cur_kind)));
    k = obs_kind();
    if (k == KTx) begin n_tx_obs++; last_tx_byte = bus.wr_data[7:0]; end
    if (k == KRx) n_rx_obs++;
    if (k == KTx || k == KRx) begin
      if (k == last_svc) n_repeat++;
      last_svc = k;
    end
  endtask

  task automatic wait_kind(input string tag, input int k, input int budget);
    for (int i = 0; i < budget && obs_kind() != k; i++) tick();
    chk(tag, 64'(obs_kind()), 64'(k));
  endtask

  task automatic push_tx(input logic [7:0] b);
    bit acc;
    bus.tx_valid = 1'b1;
    bus.tx_data  = b;
    for (int i = 0; i < 30; i++) begin
      acc = (tx_sb.size() == 0);
      tick();
      if (acc) break;
    end
    bus.tx_valid = 1'b0;
  endtask

  int base, btx, brx;

  initial begin
    reset = 1'b1; cfg_load = 1'b0; dvsr_in = 11'd0; rnd_mode = 1'b0;
    bus.tx_valid = 1'b0; bus.tx_data = 8'd0; bus.rx_ready = 1'b0; bus.rd_data = 32'd0;
    slot_tx_full = 1'b0;
    n_tx_obs = 0; n_rx_obs = 0; n_repeat = 0; last_tx_byte = 8'd0;
    model_reset();

    // Reset state
    repeat (3) tick();
    chk("reset_ready", 64'(bus.tx_ready), 64'd1);
    reset = 1'b0;

    // Divisor write then first poll
    tick();
    chk("cfg_first", 64'({bus.write, bus.addr, bus.wr_data}), 64'({1'b1, 5'd1, 32'd650}));
    tick();
    chk("poll_second", 64'({bus.read, bus.addr}), 64'({1'b1, 5'd0}));
    chk("rx_idle", 64'(bus.rx_valid), 64'd0);

    // Single TX byte
    push_tx(8'h41);
    wait_kind("wait_tx41", KTx, 10);
    chk("tx41_data", 64'(bus.wr_data), 64'h41);
    tick();
    chk("tx41_ready_back", 64'(bus.tx_ready), 64'd1);

    // TX back-pressure from a full UART TX FIFO
    slot_tx_full = 1'b1;
    push_tx(8'h55);
    base = n_tx_obs;
    repeat (20) tick();
    chk("txfull_no_write", 64'(n_tx_obs - base), 64'd0);
    chk("txfull_not_ready", 64'(bus.tx_ready), 64'd0);
    slot_tx_full = 1'b0;
    repeat (4) tick();
    chk("txfull_one_write", 64'(n_tx_obs - base), 64'd1);
    chk("txfull_byte", 64'(last_tx_byte), 64'h55);

    // RX back-pressure from the local sink
    rxf.push_back(8'h5A);
    rxf.push_back(8'h3C);
    bus.rx_ready = 1'b0;
    base = n_rx_obs;
    repeat (8) tick();
    chk("rx_held_valid", 64'(bus.rx_valid), 64'd1);
    chk("rx_held_data", 64'(bus.rx_data), 64'h5A);
    chk("rx_single_pop", 64'(n_rx_obs - base), 64'd1);
    bus.rx_ready = 1'b1;
    repeat (6) tick();
    chk("rx_second_pop", 64'(n_rx_obs - base), 64'd2);

    // Both sides continuously eligible: round-robin
    for (int i = 0; i < 10; i++) rxf.push_back(8'(8'h80 + i));
    n_repeat = 0; last_svc = KIdle; btx = n_tx_obs; brx = n_rx_obs;
    bus.tx_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      bus.tx_data = 8'(i + 16);
      tick();
    end
    bus.tx_valid = 1'b0;
    chk("rr_no_repeat", 64'(n_repeat), 64'd0);
    chk("rr_tx_served", 64'(n_tx_obs - btx >= 4), 64'd1);
    chk("rr_rx_served", 64'(n_rx_obs - brx >= 4), 64'd1);
    repeat (30) tick();

    // Divisor reload requested during a TX write
    push_tx(8'hC3);
    wait_kind("wait_tx_c3", KTx, 20);
    cfg_load = 1'b1; dvsr_in = 11'd325;
    tick();
    cfg_load = 1'b0;
    wait_kind("wait_cfg325", KCfg, 6);
    chk("cfg_325", 64'(bus.wr_data), 64'd325);

    // Reset in the middle of a TX write
    push_tx(8'h7E);
    wait_kind("wait_tx_7e", KTx, 20);
    reset = 1'b1;
    #1;
    chk("reset_drops_strobes", 64'({bus.cs, bus.write}), 64'd0);
    model_reset();
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("cfg_after_reset", 64'({bus.write, bus.addr, bus.wr_data}), 64'({1'b1, 5'd1, 32'd650}));

    // Randomized traffic against the model
    rnd_mode = 1'b1;
    repeat (600) tick();
    rnd_mode = 1'b0;
    cfg_load = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
